// File: rtl/trace_pkg.sv
// Shared types for the PC/ALU trace capture path: FIFO entry layout and serializer states.
package trace_pkg;

  localparam int TRACE_DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_PC  = 2'd1,
    SEND_ALU = 2'd2
  } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace store, registered pointers/count, combinational head; clear beats push/pop.
// Caller guarantees no push when full without a same-edge pop, and no pop when empty.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  trace_entry_t             push_data,
  input  logic                     pop,
  input  logic                     clear,
  output trace_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/trace_capture.sv
// Captures {PC, ALU} on each PC change and streams it as two 32-bit words (PC then ALU).
// rd_valid one cycle after a push into an empty store; words hold while rd_ready is low.
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             PC_out,
  input  logic [31:0]             ALU_Output,
  input  logic                    capture_en,
  input  logic                    clear,
  output logic [31:0]             rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  trace_state_t state, state_next;
  trace_entry_t head, new_entry;
  logic [31:0]  pc_prev;
  logic         capture_evt;
  logic         pop;
  logic         push;
  logic         drop;

  assign capture_evt = capture_en && !clear && (PC_out != pc_prev);
  assign pop         = (state == SEND_ALU) && rd_ready && !clear;
  assign push        = capture_evt && ((count != FULL) || pop);
  assign drop        = capture_evt && !push;
  assign new_entry   = '{pc: PC_out, alu: ALU_Output};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .clear     (clear),
    .head      (head),
    .count     (count)
  );

  // A dropped capture keeps pc_prev, so the same PC is retried once space frees up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_prev  <= 32'hFFFF_FFFF;
      overflow <= 1'b0;
      state    <= IDLE;
    end else begin
      state <= state_next;
      if (clear) begin
        pc_prev  <= 32'hFFFF_FFFF;
        overflow <= 1'b0;
      end else begin
        if (push) pc_prev  <= PC_out;
        if (drop) overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    rd_valid   = 1'b0;
    rd_data    = 32'h0;
    case (state)
      IDLE: begin
        if (count != '0) state_next = SEND_PC;
      end
      SEND_PC: begin
        rd_valid = 1'b1;
        rd_data  = head.pc;
        if (rd_ready) state_next = SEND_ALU;
      end
      SEND_ALU: begin
        rd_valid = 1'b1;
        rd_data  = head.alu;
        // Stay busy if anything remains after this pop, including a same-edge push.
        if (rd_ready) state_next = ((count > CW'(1)) || push) ? SEND_PC : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port PC_out  input  32  processor program counter under observation.
REQ-005 SHALL have port ALU_Output  input  32  processor ALU result, same cycle as PC_out.
REQ-006 SHALL have port capture_en  input  1  enables sampling.
REQ-007 SHALL have port clear  input  1  synchronous flush.
REQ-008 SHALL have port rd_data  output  32  serialized trace word.
REQ-009 SHALL have port rd_valid  output  1  rd_data valid.
REQ-010 SHALL have port rd_ready  input  1  consumer accepts rd_data.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky; at least one capture dropped.

Function
REQ-013 SHALL register the last captured PC in pc_prev; a capture event occurs on an edge where capture_en=1, clear=0 and PC_out != pc_prev.
REQ-014 SHALL, on a capture event, push entry {PC_out, ALU_Output} (64 bits) and load pc_prev with PC_out.
REQ-015 SHALL accept a push when count<DEPTH, or when count==DEPTH and a pop occurs on the same edge; otherwise drop it, set overflow, and leave pc_prev unchanged.
REQ-016 SHALL implement serializer FSM states IDLE, SEND_PC, SEND_ALU.
REQ-017 SHALL transition IDLE->SEND_PC when count!=0; SEND_PC->SEND_ALU on rd_valid&&rd_ready; SEND_ALU->SEND_PC on accept if count>1 after pop, else ->IDLE.
REQ-018 SHALL drive rd_valid=1 only in SEND_PC/SEND_ALU; rd_data = head PC in SEND_PC, head ALU in SEND_ALU, 0 in IDLE.
REQ-019 SHALL hold rd_data stable while rd_valid=1 and rd_ready=0.
REQ-020 SHALL pop the head entry only on acceptance of the SEND_ALU word; count includes the entry being serialized.
REQ-021 SHALL give rd_valid latency of exactly one cycle: push on edge N into empty FIFO -> rd_valid=1 after edge N+1.
REQ-022 SHALL update count by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-023 SHALL wrap read/write pointers modulo DEPTH.
REQ-024 SHALL, on clear=1, empty the FIFO, set count=0, FSM=IDLE, overflow=0, pc_prev=32'hFFFF_FFFF; clear beats capture and pop on the same edge.
REQ-025 SHALL keep overflow set until clear or reset.

Reset
REQ-026 SHALL, while reset=1, force count=0, rd_valid=0, rd_data=0, overflow=0, FSM=IDLE, pointers=0, pc_prev=32'hFFFF_FFFF, independent of clk.
REQ-027 SHALL discard any partially serialized entry when reset asserts mid-transfer; no capture occurs on the first edge after deassertion unless capture_en=1.

Structure
REQ-028 SHALL place DEPTH default, trace_entry_t {pc[31:0], alu[31:0]} and the FSM state enum in package trace_pkg.
REQ-029 SHALL implement storage as sub-module trace_fifo (push, pop, clear, head, count), with serializer FSM and capture logic in trace_capture.

Verification
REQ-030 Reset, capture_en=1, PC_out=0x0, ALU=0x5 -> after 1 cycle rd_valid=1, rd_data=0x0; accept -> 0x5; accept -> IDLE, count=0.
REQ-031 PC_out held 0x4 for 5 cycles, capture_en=1 -> exactly one entry, count=1.
REQ-032 rd_ready=0, PC_out increments by 4 for 20 distinct values -> count=16, overflow=1, first 16 pairs drained in order (PC 0x0..0x3C).
REQ-033 count=16, SEND_ALU accept on same edge as new capture -> push accepted, count stays 16, overflow stays 0.
REQ-034 clear asserted with rd_valid=1 in SEND_ALU and capture pending -> next cycle count=0, rd_valid=0, overflow=0, no entry added.
REQ-035 reset asserted mid SEND_PC between clock edges -> rd_valid=0 immediately, count=0 before next edge.
